// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, hazard
// priority rows, the enable/flush bundle and the row-to-pattern decode.
package pipeline_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        DROP_FETCH = 2'd2
    } state_t;

    // Highest-priority active request this cycle, in descending priority.
    typedef enum logic [2:0] {
        ROW_MEM_STALL = 3'd0,
        ROW_EXCEPTION = 3'd1,
        ROW_REDIRECT  = 3'd2,
        ROW_EX_BUSY   = 3'd3,
        ROW_LOADUSE   = 3'd4,
        ROW_IF_STALL  = 3'd5,
        ROW_NONE      = 3'd6
    } row_t;

    typedef struct packed {
        logic pc_ena;
        logic if_id_ena;
        logic id_ex_ena;
        logic ex_mem_ena;
        logic mem_wb_ena;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } ctrl_t;

    function automatic row_t classify(input logic mem_stall, input logic exception,
                                      input logic redirect, input logic ex_busy,
                                      input logic loaduse, input logic if_stall);
        if (mem_stall)      return ROW_MEM_STALL;
        else if (exception) return ROW_EXCEPTION;
        else if (redirect)  return ROW_REDIRECT;
        else if (ex_busy)   return ROW_EX_BUSY;
        else if (loaduse)   return ROW_LOADUSE;
        else if (if_stall)  return ROW_IF_STALL;
        else                return ROW_NONE;
    endfunction

    // A flushed stage is always enabled so the bubble is actually loaded.
    function automatic ctrl_t row_pattern(input row_t row);
        ctrl_t c;
        c = '{pc_ena: 1'b1, if_id_ena: 1'b1, id_ex_ena: 1'b1, ex_mem_ena: 1'b1,
              mem_wb_ena: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};
        case (row)
            ROW_MEM_STALL: c = '0;
            ROW_EXCEPTION: begin
                c.if_id_flush  = 1'b1;
                c.id_ex_flush  = 1'b1;
                c.ex_mem_flush = 1'b1;
            end
            ROW_REDIRECT: begin
                c.if_id_flush = 1'b1;
                c.id_ex_flush = 1'b1;
            end
            ROW_EX_BUSY: begin
                c.pc_ena       = 1'b0;
                c.if_id_ena    = 1'b0;
                c.id_ex_ena    = 1'b0;
                c.ex_mem_flush = 1'b1;
            end
            ROW_LOADUSE: begin
                c.pc_ena      = 1'b0;
                c.if_id_ena   = 1'b0;
                c.id_ex_flush = 1'b1;
            end
            ROW_IF_STALL: begin
                c.pc_ena      = 1'b0;
                c.if_id_flush = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall requests from the pipeline stages and the register enables/bubble
// strobes returned to them. master = sequencer side, slave = datapath side.
interface pipeline_ctrl_if;
    logic i_if_stall_req;
    logic i_id_loaduse;
    logic i_ex_busy;
    logic i_mem_stall_req;
    logic i_ex_redirect;
    logic i_mem_exception;
    logic o_pc_ena;
    logic o_if_id_ena;
    logic o_id_ex_ena;
    logic o_ex_mem_ena;
    logic o_mem_wb_ena;
    logic o_if_id_flush;
    logic o_id_ex_flush;
    logic o_ex_mem_flush;

    modport master (
        input  i_if_stall_req, i_id_loaduse, i_ex_busy,
               i_mem_stall_req, i_ex_redirect, i_mem_exception,
        output o_pc_ena, o_if_id_ena, o_id_ex_ena, o_ex_mem_ena, o_mem_wb_ena,
               o_if_id_flush, o_id_ex_flush, o_ex_mem_flush
    );

    modport slave (
        output i_if_stall_req, i_id_loaduse, i_ex_busy,
               i_mem_stall_req, i_ex_redirect, i_mem_exception,
        input  o_pc_ena, o_if_id_ena, o_id_ex_ena, o_ex_mem_ena, o_mem_wb_ena,
               o_if_id_flush, o_id_ex_flush, o_ex_mem_flush
    );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Up-counter that holds at MAX instead of wrapping; clear wins over increment.
module pipeline_ctrl_sat_counter #(
    parameter int           W   = 32,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_max
);

    assign o_max = (o_cnt == MAX);

    // Count register: clear, else increment until MAX is reached.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_inc && !o_max) begin
            o_cnt <= o_cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
//   state      | meaning
//   RUN        | normal issue; requests decoded by priority
//   MEM_WAIT   | memory stage stalled, whole pipe frozen
//   DROP_FETCH | redirect taken while a fetch was in flight; discard it on return
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    pipeline_ctrl_if.master      bus,
    output logic [STATE_W-1:0]   o_state,
    output logic [CNT_W-1:0]     o_stall_cycles,
    output logic                 o_mem_timeout
);

    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_t            state_q, state_d;
    row_t              row;
    ctrl_t             ctrl;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_max;
    logic              timeout_q;
    logic              stall_max;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= RUN;
        else         state_q <= state_d;
    end

    // Priority decode of requests into enables/flushes plus next-state selection.
    always_comb begin
        row     = classify(bus.i_mem_stall_req, bus.i_mem_exception, bus.i_ex_redirect,
                           bus.i_ex_busy, bus.i_id_loaduse, bus.i_if_stall_req);
        ctrl    = row_pattern(row);
        state_d = state_q;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (row == ROW_MEM_STALL)
                    state_d = MEM_WAIT;
                else if ((row == ROW_EXCEPTION || row == ROW_REDIRECT) && bus.i_if_stall_req)
                    state_d = DROP_FETCH;
                else
                    state_d = RUN;
            end
            DROP_FETCH: begin
                if (row == ROW_NONE) begin
                    // Stale fetch lands now: hold PC, squash what it delivered.
                    ctrl.pc_ena      = 1'b0;
                    ctrl.if_id_flush = 1'b1;
                    state_d          = RUN;
                end else if ((row == ROW_EXCEPTION || row == ROW_REDIRECT) &&
                             !bus.i_if_stall_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.o_pc_ena       = ctrl.pc_ena;
    assign bus.o_if_id_ena    = ctrl.if_id_ena;
    assign bus.o_id_ex_ena    = ctrl.id_ex_ena;
    assign bus.o_ex_mem_ena   = ctrl.ex_mem_ena;
    assign bus.o_mem_wb_ena   = ctrl.mem_wb_ena;
    assign bus.o_if_id_flush  = ctrl.if_id_flush;
    assign bus.o_id_ex_flush  = ctrl.id_ex_flush;
    assign bus.o_ex_mem_flush = ctrl.ex_mem_flush;
    assign o_state            = state_q;

    pipeline_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .resetn (resetn),
        .i_inc  (!ctrl.pc_ena),
        .i_clr  (1'b0),
        .o_cnt  (o_stall_cycles),
        .o_max  (stall_max)
    );

    pipeline_ctrl_sat_counter #(.W(WAIT_W), .MAX(WAIT_MAX)) u_wait_cnt (
        .clk    (clk),
        .resetn (resetn),
        .i_inc  (row == ROW_MEM_STALL),
        .i_clr  (row != ROW_MEM_STALL),
        .o_cnt  (wait_cnt),
        .o_max  (wait_max)
    );

    // Sticky timeout; the OR with wait_max makes it visible on the edge the count hits TIMEOUT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       timeout_q <= 1'b0;
        else if (wait_max) timeout_q <= 1'b1;
    end

    assign o_mem_timeout = timeout_q | wait_max;

endmodule
